// File: rtl/ready_valid_rr_arbiter.sv
// Round-robin N-to-1 ready-valid arbiter with a 2-entry output buffer and source id tagging.
// Optional packet locking (contiguous packets) is enabled with `define RV_ARB_PACKET_LOCK_EN.
module ready_valid_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          out_last,
    input  logic                          out_ready
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
    } beat_t;

    beat_t                 mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;
    logic [ID_WIDTH-1:0]   ptr;

    logic                  space;
    logic                  push;
    logic                  pop;
    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [NUM_REQ-1:0]    eligible;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_last;

`ifdef RV_ARB_PACKET_LOCK_EN
    logic                  lock;
    logic [ID_WIDTH-1:0]   lock_id;
`endif

    // Index base+k modulo NUM_REQ without a divider; k never exceeds NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] offset_idx(input logic [ID_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    // Space depends only on registered occupancy, so out_ready never reaches in_ready.
    assign space     = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = |(in_valid & in_ready);

    always_comb begin
        eligible = in_valid;
`ifdef RV_ARB_PACKET_LOCK_EN
        if (lock) begin
            eligible          = '0;
            eligible[lock_id] = in_valid[lock_id];
        end
`endif
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[offset_idx(ptr, k)]) begin
                found  = 1'b1;
                winner = offset_idx(ptr, k);
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_WIDTH'(i)) begin
                win_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_last = in_last[i];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && space && found) in_ready[winner] = 1'b1;
    end

    assign out_data = mem[rd_ptr].data;
    assign out_id   = mem[rd_ptr].id;
    assign out_last = mem[rd_ptr].last;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ptr    <= '0;
            // NOTE: the buffer entries are reset because the head entry is visible on out_data.
            mem[0] <= '0;
            mem[1] <= '0;
`ifdef RV_ARB_PACKET_LOCK_EN
            lock    <= 1'b0;
            lock_id <= '0;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: win_data, id: winner, last: win_last};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase

`ifdef RV_ARB_PACKET_LOCK_EN
            // The pointer only moves at packet boundaries; mid-packet beats hold the lock.
            if (push) begin
                if (!win_last) begin
                    lock    <= 1'b1;
                    lock_id <= winner;
                end else begin
                    lock <= 1'b0;
                    ptr  <= offset_idx(winner, 1);
                end
            end
`else
            if (push) ptr <= offset_idx(winner, 1);
`endif
        end
    end

endmodule

// File: doc/ready_valid_rr_arbiter.md
# ready_valid_rr_arbiter

N-to-1 round-robin arbiter that shares one downstream ready-valid channel among `NUM_REQ` requesters. It drives the input end of a skid pipeline or any single ready-valid consumer. It has a 2-entry output buffer, so the arbiter sustains one beat per cycle and has no combinational path from `out_ready` to any `in_ready`. Each output beat carries the index of the requester that sent it.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `DATA_WIDTH`, 8, payload width per beat.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, derived localparam; do not override.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input `NUM_REQ`: bit i is the valid of requester i.
- `in_data` input `NUM_REQ*DATA_WIDTH`: requester i's payload is slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_last` input `NUM_REQ`: end-of-packet marker per requester.
- `in_ready` output `NUM_REQ`: one-hot or zero; grant and accept for requester i.
- `out_valid` output 1: an output beat is present.
- `out_data` output `DATA_WIDTH`: output payload.
- `out_id` output `ID_WIDTH`: source requester of the output beat.
- `out_last` output 1: copy of the source `in_last`.
- `out_ready` input 1: downstream accept.

## Operation
- Output buffer: 2-entry FIFO of {data, id, last} with occupancy `cnt` in 0..2.
  - Push = any `in_valid[i] & in_ready[i]`.
  - Pop = `out_valid & out_ready`.
  - A push and a pop in the same cycle leave `cnt` unchanged.
- Output `out_valid` = (`cnt != 0`); `out_data`, `out_id` and `out_last` show the head entry.
- Space flag `space` = (`cnt != 2`); this is a function of registered state only.
- Winner selection:
  - Scan `in_valid` starting at pointer `ptr` and wrapping modulo `NUM_REQ`. The first set bit wins.
  - `in_ready[winner]` = `space`; every other `in_ready` bit is 0.
  - With no valid requester, `in_ready` = 0.
- Pointer update: on an accepted beat from requester i, `ptr <= (i+1) mod NUM_REQ`. With `NUM_REQ` not a power of 2, index `NUM_REQ-1` wraps to 0.
- A requester that deasserts `in_valid` before acceptance loses its turn with no penalty.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- Reset mid-operation: buffered beats are discarded, the pointer returns to 0 and the lock (see Configuration) is cleared.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_id`=0, `out_last`=0.
  - `in_ready`=0 while `reset` is high.
  - `ptr`=0, `cnt`=0, lock=0.
- Latency: a beat accepted at edge N is presented on `out_valid` after edge N when the buffer was empty. This is 1 cycle; the block has no bypass path.
- Throughput: 1 beat/cycle while `out_ready`=1. `cnt` holds at 1 under continuous flow.
- Backpressure: with `out_ready`=0, at most 2 more beats are accepted, then all `in_ready`=0.
- Combinational path `in_valid` -> `in_ready` is allowed. Path `out_ready` -> `in_ready` is forbidden.
- `out_*` are stable while `out_valid & !out_ready`.

## Configuration
- Macro: `RV_ARB_PACKET_LOCK_EN`.
- When defined:
  - Accepting a beat with `in_last`=0 from requester i sets `lock`=1 and `lock_id`=i.
  - While locked, only `lock_id` is eligible and `ptr` is frozen.
  - An accepted beat with `in_last`=1 from `lock_id` clears `lock` and sets `ptr <= lock_id+1`.
  - Packets therefore reach the output contiguously.
- When undefined: arbitration is per beat, and `in_last` is only carried through to `out_last`.

## Test plan
- Reset then idle: assert `reset` for 2 cycles with all `in_valid`=1. Required: `in_ready`=0, `out_valid`=0 and `out_data`=0 during reset. The first accept after reset is requester 0.
- Fairness: `NUM_REQ`=4, all four requesters hold `in_valid`, `out_ready`=1. Required: `out_id` sequence is 0,1,2,3,0,1… with one beat per cycle. Each `out_data` matches the payload of its source.
- Backpressure: one requester streams 0x10,0x11,0x12,…; `out_ready`=0 for 5 cycles. Required: exactly 2 beats (0x10, 0x11) are accepted, then `in_ready`=0. On `out_ready`=1, beats drain in order with no loss.
- Sparse and wrap: only requesters 3 and 1 valid, `ptr`=2. Required: 3 wins, then 1, then 3.
  - With `NUM_REQ`=3: after requester 2 wins, `ptr`=0.
- Packet lock (`RV_ARB_PACKET_LOCK_EN`): requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is continuously valid. Required: `out_id` = 0,0,0,1.
  - Without the macro, the same stimulus gives `out_id` = 0,1,0,1,0.
- Reset mid-operation: `cnt`=2 and lock set, then assert `reset`. Required: the next cycle shows `out_valid`=0, and arbitration restarts from requester 0.
